uart_rx_ctrl: RTL and testbench

Controller that sequences the UART `receiver` and buffers its output for the host side. It gates the receiver's `en` and detects each completed byte on the rising edge of `rdy`. Completed bytes are pushed into a small show-ahead FIFO, which the host drains with a valid/ready handshake. The block also watches the serial line for frame start and flags frames that never complete, plus overruns.

---
 rtl/uart_rx_ctrl_pkg.sv | 16 +
 rtl/uart_rx_ctrl_if.sv | 12 +
 rtl/uart_fifo.sv | 75 +++++++
 rtl/uart_rx_ctrl.sv | 110 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
// State encodings, data width and default timeout formerly lived in uart_defs.vh.
package uart_rx_ctrl_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEF_TIMEOUT = 10;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    CTRL_OFF   = 2'd0,
    CTRL_ARMED = 2'd1,
    CTRL_FRAME = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side show-ahead handshake between the controller FIFO and its consumer.
interface uart_rx_ctrl_if;
  import uart_rx_ctrl_pkg::*;

  logic  out_valid;
  data_t out_data;
  logic  out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/uart_fifo.sv
// Show-ahead byte FIFO with a separate occupancy counter and synchronous flush.
module uart_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  data_t                    din,
  output data_t                    dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  data_t         mem_q [DEPTH];
  data_t         mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same edge, so a push into a full FIFO is accepted alongside it.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the UART receiver, captures completed bytes on the rdy rising edge
// into a show-ahead FIFO, and flags frame timeouts and overruns.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   clr_err,
  input  logic                   rx_line,
  input  logic                   rx_rdy,
  input  data_t                  rx_data,
  output logic                   rx_en,
  uart_rx_ctrl_if.master         host,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  output logic                   frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  ctrl_state_e   state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rdy_q;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          rise, push, pop, timeout, full, empty, drop;

  assign rise           = rx_rdy && !rdy_q;
  assign pop            = host.out_valid && host.out_ready;
  assign host.out_valid = !empty;
  assign drop           = push && full && !pop && !flush;
  assign overrun        = overrun_q;
  assign frame_err      = frame_err_q;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    push    = 1'b0;
    timeout = 1'b0;
    rx_en   = 1'b0;
    unique case (state_q)
      CTRL_OFF: begin
        if (enable) state_d = CTRL_ARMED;
      end
      CTRL_ARMED: begin
        rx_en = enable;
        if (!rx_line) begin
          state_d = CTRL_FRAME;
          tmo_d   = '0;
        end
      end
      CTRL_FRAME: begin
        rx_en = enable;
        tmo_d = tmo_q + 1'b1;
        if (rise) begin
          push    = enable;
          state_d = CTRL_ARMED;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          timeout = enable;
          state_d = CTRL_ARMED;
        end
      end
      default: state_d = CTRL_OFF;
    endcase
    // Dropping enable discards any partial frame regardless of state.
    if (!enable) state_d = CTRL_OFF;
  end

  always_comb begin
    overrun_d   = drop || (overrun_q && !clr_err);
    frame_err_d = timeout || (frame_err_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CTRL_OFF;
      tmo_q       <= '0;
      rdy_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      rdy_q       <= rx_rdy;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rx_data),
    .dout  (host.out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model of the FIFO and flags.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 10;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic          rx_line = 1'b1;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_en;
  logic [CW-1:0] count;
  logic          overrun;
  logic          frame_err;

  uart_rx_ctrl_if host_if ();

  uart_rx_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .flush     (flush),
    .clr_err   (clr_err),
    .rx_line   (rx_line),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rx_en     (rx_en),
    .host      (host_if),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  bit         m_ovr = 1'b0;
  bit         m_ferr = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: model applies pop/flush/push from the pre-edge inputs, then the DUT is compared.
  task automatic step(input bit push_ev, input bit to_ev);
    bit         exp_pop;
    bit         ovr_ev;
    logic [7:0] d;
    exp_pop = (q.size() != 0) && (host_if.out_ready === 1'b1) && !flush;
    d       = rx_data;
    ovr_ev  = 1'b0;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (push_ev) begin
        if (q.size() < DEPTH) q.push_back(d);
        else ovr_ev = 1'b1;
      end
    end
    if (clr_err) begin
      m_ovr  = ovr_ev;
      m_ferr = to_ev;
    end else begin
      m_ovr  = m_ovr | ovr_ev;
      m_ferr = m_ferr | to_ev;
    end
    n_checks++;
    if (count !== CW'(q.size())) begin
      n_fail++;
      $display("FAIL count: got %0d expected %0d at %0t", count, q.size(), $time);
    end
    n_checks++;
    if (host_if.out_valid !== (q.size() != 0)) begin
      n_fail++;
      $display("FAIL out_valid: got %b expected %b at %0t", host_if.out_valid, q.size() != 0, $time);
    end
    if (q.size() != 0) begin
      n_checks++;
      if (host_if.out_data !== q[0]) begin
        n_fail++;
        $display("FAIL out_data: got %02h expected %02h at %0t", host_if.out_data, q[0], $time);
      end
    end
    n_checks++;
    if (overrun !== m_ovr) begin
      n_fail++;
      $display("FAIL overrun: got %b expected %b at %0t", overrun, m_ovr, $time);
    end
    n_checks++;
    if (frame_err !== m_ferr) begin
      n_fail++;
      $display("FAIL frame_err: got %b expected %b at %0t", frame_err, m_ferr, $time);
    end
  endtask

  // mode 0: never ready; 1: random ready every cycle; 2: ready only in the rdy cycle
  task automatic send_frame(input logic [7:0] b, input int mode);
    rx_line           = 1'b0;
    host_if.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rx_line           = b[i];
      host_if.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1'b0, 1'b0);
    end
    rx_line           = 1'b1;
    rx_rdy            = 1'b1;
    rx_data           = b;
    host_if.out_ready = (mode == 0) ? 1'b0 : ((mode == 2) ? 1'b1 : 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0);
    rx_rdy            = 1'b0;
    host_if.out_ready = 1'b0;
  endtask

  task automatic drain();
    host_if.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (q.size() != 0) step(1'b0, 1'b0);
    end
    host_if.out_ready = 1'b0;
    n_checks++;
    if (count !== '0) begin
      n_fail++;
      $display("FAIL drain_empty: got count %0d expected 0", count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    host_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rx_en, host_if.out_valid, overrun, frame_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {rx_en, host_if.out_valid, overrun, frame_err});
    end
    n_checks++;
    if (count !== '0 || host_if.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_fifo: got count %0d data %02h expected 0 00", count, host_if.out_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_line = 1'($urandom_range(0, 1));
      step(1'b0, 1'b0);
      n_checks++;
      if (rx_en !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_rx_en: got %b expected 0", rx_en);
      end
    end
    rx_line = 1'b1;
  endtask

  task automatic test_single_byte();
    enable = 1'b1;
    step(1'b0, 1'b0);
    n_checks++;
    if (rx_en !== 1'b1) begin
      n_fail++;
      $display("FAIL armed_rx_en: got %b expected 1", rx_en);
    end
    send_frame(8'h55, 0);
    n_checks++;
    if (host_if.out_data !== 8'h55 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_byte: got data %02h count %0d expected 55 1", host_if.out_data, count);
    end
    host_if.out_ready = 1'b1;
    step(1'b0, 1'b0);
    host_if.out_ready = 1'b0;
    n_checks++;
    if (count !== '0 || host_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: got count %0d valid %b expected 0 0", count, host_if.out_valid);
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    n_checks++;
    if (count !== CW'(DEPTH) || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_overrun: got count %0d overrun %b expected 4 1", count, overrun);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (host_if.out_data !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL pop_order: got %02h expected %02h", host_if.out_data, 8'(i + 1));
      end
      host_if.out_ready = 1'b1;
      step(1'b0, 1'b0);
      host_if.out_ready = 1'b0;
    end
    n_checks++;
    if (host_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL byte5_absent: got valid %b expected 0", host_if.out_valid);
    end
    clr_err = 1'b1;
    step(1'b0, 1'b0);
    clr_err = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: got overrun %b expected 0", overrun);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b[5];
    for (int i = 0; i < 5; i++) exp_b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 0);
    send_frame(exp_b[4], 2);
    n_checks++;
    if (count !== CW'(DEPTH) || host_if.out_data !== exp_b[1] || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: got count %0d head %02h ovr %b expected 4 %02h 0",
               count, host_if.out_data, overrun, exp_b[1]);
    end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (host_if.out_data !== exp_b[i]) begin
        n_fail++;
        $display("FAIL full_tail_order: got %02h expected %02h", host_if.out_data, exp_b[i]);
      end
      host_if.out_ready = 1'b1;
      step(1'b0, 1'b0);
      host_if.out_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int unsigned c0;
    rx_line = 1'b0;
    step(1'b0, 1'b0);
    rx_line = 1'b1;
    repeat (TO - 1) step(1'b0, 1'b0);
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got frame_err %b expected 0", frame_err);
    end
    step(1'b0, 1'b1);
    n_checks++;
    if (frame_err !== 1'b1 || count !== '0 || rx_en !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: got ferr %b count %0d rx_en %b expected 1 0 1", frame_err, count, rx_en);
    end
    c0 = q.size();
    send_frame(8'hA7, 0);
    n_checks++;
    if (count !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL timeout_rearmed: got count %0d expected %0d", count, c0 + 1);
    end
    clr_err = 1'b1;
    step(1'b0, 1'b0);
    clr_err = 1'b0;
    drain();
  endtask

  task automatic test_stale_flush();
    send_frame(8'h3C, 0);
    rx_rdy = 1'b1;
    enable = 1'b0;
    #1;
    n_checks++;
    if (rx_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_en_comb: got %b expected 0", rx_en);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    enable = 1'b1;
    step(1'b0, 1'b0);
    rx_line = 1'b0;
    step(1'b0, 1'b0);
    rx_line = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(1)) begin
      n_fail++;
      $display("FAIL stale_rdy: got count %0d expected 1", count);
    end
    rx_rdy = 1'b0;
    enable = 1'b0;
    step(1'b0, 1'b0);
    enable = 1'b1;
    step(1'b0, 1'b0);
    flush = 1'b1;
    step(1'b0, 1'b0);
    flush = 1'b0;
    n_checks++;
    if (count !== '0 || host_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: got count %0d valid %b expected 0 0", count, host_if.out_valid);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 16; f++) begin
      int unsigned gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < int'(gap); g++) begin
        host_if.out_ready = 1'($urandom_range(0, 1));
        step(1'b0, 1'b0);
      end
      send_frame(8'($urandom), 1);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    send_frame(8'h91, 0);
    send_frame(8'h92, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (count !== '0 || host_if.out_valid !== 1'b0 || rx_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got count %0d valid %b rx_en %b expected 0 0 0",
               count, host_if.out_valid, rx_en);
    end
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0);
    send_frame(8'hE4, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overrun();
    test_full_push_pop();
    test_timeout();
    test_stale_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
